pe_tile_param: RTL and testbench
================================

PE_TILE_PARAM -- requirements
Module: pe_tile_param

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 16: track and PE datapath width in bits.
- NUM_TRACKS, default 4: tracks per side; 4 sides are fixed.
REQ-002 Ports SHALL be as follows (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- tile_id  in  16  this tile's address.
- config_addr  in  32  [15:0] tile, [23:16] block, [31:24] register index.
- config_data  in  32  write payload.
- config_valid  in  1  write request.
- config_ready  out  1  write accepted when valid&ready.
- config_done  out  1  one-cycle pulse when a commit completes.
- config_err  out  1  one-cycle pulse on a bad block/index.
- in_wire  in  4*NUM_TRACKS*WIDTH  side s, track t at slice (s*NUM_TRACKS+t)*WIDTH.
- out_wire  out  4*NUM_TRACKS*WIDTH  same packing as in_wire.
- pe_out  out  WIDTH  PE result, exported for observation.

Function
REQ-003 Config FSM SHALL have states IDLE, WRITE and COMMIT; config_ready SHALL be 1 only in IDLE.
REQ-004 Accept (valid&ready with config_addr[15:0]==tile_id) SHALL transition:
- block 0xFE -> COMMIT;
- any other block -> WRITE.
A non-matching tile id SHALL be consumed, stay in IDLE and have no effect.
REQ-005 WRITE SHALL update the shadow register selected by block/index, then return to IDLE.
- Blocks: 0 = cb0, 1 = cb1, 2 = pe op, 3 = sb; the sb index is s*NUM_TRACKS+t.
- Max throughput SHALL be one write per 2 cycles.
REQ-006 Block not in {0,1,2,3,0xFE}, or sb index >= 4*NUM_TRACKS, SHALL pulse config_err in WRITE and write nothing.
REQ-007 COMMIT SHALL copy every shadow register to its active register in one cycle, pulse config_done, and return to IDLE.
- The datapath SHALL use active registers only.
- Shadow writes SHALL never affect outputs before a commit.
REQ-008 Field widths (low bits of config_data):
- cb select: clog2(2*NUM_TRACKS) bits;
- pe op: 3 bits;
- sb select: 2 bits.
Higher bits SHALL be ignored.
REQ-009 cbN (N = 0, 1) SHALL drive operand N:
- select k < NUM_TRACKS -> in_wire side 0, track k;
- otherwise -> out_wire side 0, track k-NUM_TRACKS.
REQ-010 PE ops (mod 2^WIDTH) SHALL be: 0 a+b, 1 a-b, 2 a&b, 3 a|b, 4 a^b, 5 a, 6 b, 7 zero.
REQ-011 sb output side s, track t SHALL drive:
- select 0..2 -> in_wire track t of the other three sides, in ascending side order skipping s;
- select 3 -> pe_out.
REQ-012 With active cb select 0 on both cbs and sb select 0 everywhere, no combinational loop SHALL exist.
- A cb selecting an out_wire whose sb selects pe_out is a configuration error left to software.
- It is legal only when PE_OUTPUT_REG_EN is defined.

Reset
REQ-013 Asserting reset (low) SHALL asynchronously:
- force the FSM to IDLE;
- zero all shadow and active registers and the PE output register;
- drive config_done=0 and config_err=0.
REQ-014 Reset mid-WRITE or mid-COMMIT SHALL discard the operation; all registers read zero after release.
REQ-015 After release, config_ready SHALL be 1 on the first clock edge.

Configuration
REQ-016 Macro PE_OUTPUT_REG_EN:
- Defined: pe_out SHALL be registered (one-cycle latency from operand change), reset value 0.
- Undefined: pe_out SHALL be combinational (zero latency), and the register SHALL be absent.

Verification
REQ-017 Bench (WIDTH=16, NUM_TRACKS=4) SHALL cover:
- Reset then no commit: every out_wire = in_wire of the lower-numbered other side (side 0 outputs = side 1 inputs); pe_out = 0x0000+0x0000 = 0.
- Write cb0=1, cb1=2, pe op=0, then commit: in_wire s0t1=0x1234 and s0t2=0x0001 -> pe_out=0x1235; config_done high exactly one cycle.
- Op 1 with a=0x0000, b=0x0001 -> pe_out=0xFFFF (wrap).
- Write sb index 5 (side 1, track 1)=3 without commit -> out s1t1 unchanged; after commit -> out s1t1 = pe_out.
- Write to block 0x07 -> config_err one cycle; no register changes; back-to-back valid -> config_ready low in the cycle after each accept.
- Assert reset during COMMIT -> active registers zero and config_done never pulses; with PE_OUTPUT_REG_EN, pe_out lags operands by exactly one cycle.

Source files
------------

// File: rtl/pe_tile_param.sv
// Config-programmable CGRA tile: two connection boxes feed a PE, a switch box routes tracks; shadow/active config regs.
// Latency: config write 2 cycles (accept + WRITE), commit visible the cycle config_done is high; pe_out 0 cycles (1 with PE_OUTPUT_REG_EN).
// Backpressure: config_ready is high only in IDLE, so the port takes at most one request per 2 cycles.
module pe_tile_param #(
    parameter int WIDTH      = 16,
    parameter int NUM_TRACKS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [15:0]                     tile_id,
    input  logic [31:0]                     config_addr,
    input  logic [31:0]                     config_data,
    input  logic                            config_valid,
    output logic                            config_ready,
    output logic                            config_done,
    output logic                            config_err,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]   in_wire,
    output logic [4*NUM_TRACKS*WIDTH-1:0]   out_wire,
    output logic [WIDTH-1:0]                pe_out
);
    // Optional feature macro: PE_OUTPUT_REG_EN registers pe_out.

    localparam int NL  = 4 * NUM_TRACKS;
    localparam int CBW = $clog2(2 * NUM_TRACKS);
    localparam int DW  = (CBW > 3) ? CBW : 3;
    localparam logic [7:0] BLK_COMMIT = 8'hFE;

    typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_t;

    state_t                       state, state_nxt;
    logic                         accept, tile_hit, wr_bad;
    logic [7:0]                   wr_blk, wr_idx;
    logic [DW-1:0]                wr_dat;
    logic [1:0][CBW-1:0]          cb_shd, cb_act;
    logic [2:0]                   op_shd, op_act;
    logic [NL-1:0][1:0]           sb_shd, sb_act;
    logic [NL-1:0][WIDTH-1:0]     in_lane, out_lane, sb_in;
    logic [1:0][WIDTH-1:0]        opnd;
    logic [WIDTH-1:0]             pe_res, pe_fb;
    logic                         unused_cfg_bits;

    assign accept          = config_valid && config_ready;
    assign tile_hit        = (config_addr[15:0] == tile_id);
    assign unused_cfg_bits = ^config_data[31:DW];
    assign in_lane         = in_wire;
    assign out_wire        = out_lane;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: requests for other tiles are consumed without leaving IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && tile_hit)
                         state_nxt = (config_addr[23:16] == BLK_COMMIT) ? COMMIT : WRITE;
            WRITE:   state_nxt = IDLE;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, error flagged while the bad write is in WRITE
    always_comb begin
        config_ready = (state == IDLE);
        config_err   = (state == WRITE) && wr_bad;
    end

    // Capture the addressed request so WRITE works from stable values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_blk <= '0;
            wr_idx <= '0;
            wr_dat <= '0;
        end else if (accept && tile_hit) begin
            wr_blk <= config_addr[23:16];
            wr_idx <= config_addr[31:24];
            wr_dat <= config_data[DW-1:0];
        end
    end

    // Decode of unknown blocks and out-of-range switch-box indices
    always_comb begin
        case (wr_blk)
            8'd0, 8'd1, 8'd2: wr_bad = 1'b0;
            8'd3:             wr_bad = (int'(wr_idx) >= NL);
            default:          wr_bad = 1'b1;
        endcase
    end

    // Shadow register writes; upper payload bits are simply not stored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cb_shd <= '0;
            op_shd <= '0;
            sb_shd <= '0;
        end else if (state == WRITE && !wr_bad) begin
            case (wr_blk)
                8'd0: cb_shd[0] <= wr_dat[CBW-1:0];
                8'd1: cb_shd[1] <= wr_dat[CBW-1:0];
                8'd2: op_shd    <= wr_dat[2:0];
                8'd3: for (int i = 0; i < NL; i++)
                          if (int'(wr_idx) == i) sb_shd[i] <= wr_dat[1:0];
                default: ;
            endcase
        end
    end

    // Commit copies the whole shadow set at once; done pulses with the new config live
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cb_act      <= '0;
            op_act      <= '0;
            sb_act      <= '0;
            config_done <= 1'b0;
        end else begin
            config_done <= (state == COMMIT);
            if (state == COMMIT) begin
                cb_act <= cb_shd;
                op_act <= op_shd;
                sb_act <= sb_shd;
            end
        end
    end

    // Switch box: selects 0..2 pick the other sides in ascending order, 3 picks the PE.
    // sb_in holds only the track-sourced value so the cb path never depends on out_wire.
    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
            localparam int IDX = s * NUM_TRACKS + t;
            localparam int L0  = ((s == 0) ? 1 : 0) * NUM_TRACKS + t;
            localparam int L1  = ((s <= 1) ? 2 : 1) * NUM_TRACKS + t;
            localparam int L2  = ((s <= 2) ? 3 : 2) * NUM_TRACKS + t;
            assign sb_in[IDX]    = (sb_act[IDX] == 2'd0) ? in_lane[L0] :
                                   (sb_act[IDX] == 2'd1) ? in_lane[L1] :
                                   (sb_act[IDX] == 2'd2) ? in_lane[L2] : '0;
            assign out_lane[IDX] = (sb_act[IDX] == 2'd3) ? pe_out : sb_in[IDX];
        end
    end

    // Connection boxes: low selects read side-0 inputs, high selects read side-0 outputs
    always_comb begin
        opnd = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < NUM_TRACKS; j++) begin
                if (int'(cb_act[i]) == j)
                    opnd[i] = in_lane[j];
                if (int'(cb_act[i]) == j + NUM_TRACKS)
                    opnd[i] = (sb_act[j] == 2'd3) ? pe_fb : sb_in[j];
            end
        end
    end

    // PE ALU, all arithmetic wraps at WIDTH bits
    always_comb begin
        case (op_act)
            3'd0:    pe_res = opnd[0] + opnd[1];
            3'd1:    pe_res = opnd[0] - opnd[1];
            3'd2:    pe_res = opnd[0] & opnd[1];
            3'd3:    pe_res = opnd[0] | opnd[1];
            3'd4:    pe_res = opnd[0] ^ opnd[1];
            3'd5:    pe_res = opnd[0];
            3'd6:    pe_res = opnd[1];
            default: pe_res = '0;
        endcase
    end

`ifdef PE_OUTPUT_REG_EN
    logic [WIDTH-1:0] pe_q;

    // Registered PE result; this register is what makes cb<-sb<-pe feedback legal
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pe_q <= '0;
        else        pe_q <= pe_res;
    end

    assign pe_out = pe_q;
    assign pe_fb  = pe_q;
`else
    // Without the register a cb reading a PE-driven out_wire would loop; it sees zero instead
    assign pe_out = pe_res;
    assign pe_fb  = '0;
`endif

endmodule

// File: tb/tb_pe_tile_param.sv
module tb_pe_tile_param;
    localparam int W  = 16;
    localparam int NT = 4;
    localparam int NL = 4 * NT;
    localparam logic [15:0] TID = 16'h0042;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       tile_id;
    logic [31:0]       config_addr, config_data;
    logic              config_valid;
    logic              config_ready, config_done, config_err;
    logic [NL*W-1:0]   in_wire, out_wire;
    logic [W-1:0]      pe_out;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_pe;
    } vec_t;
    vec_t vecs[9];

    pe_tile_param #(.WIDTH(W), .NUM_TRACKS(NT)) dut (
        .clk(clk), .reset(reset), .tile_id(tile_id),
        .config_addr(config_addr), .config_data(config_data), .config_valid(config_valid),
        .config_ready(config_ready), .config_done(config_done), .config_err(config_err),
        .in_wire(in_wire), .out_wire(out_wire), .pe_out(pe_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] out_lane(input int i);
        return out_wire[i*W +: W];
    endfunction

    function automatic logic [W-1:0] in_lane(input int i);
        return in_wire[i*W +: W];
    endfunction

    task automatic set_lane(input int i, input logic [W-1:0] v);
        in_wire[i*W +: W] = v;
    endtask

    // Drive one request and return #1 after the edge that accepted it, valid dropped
    task automatic send(input logic [7:0] blk, input logic [7:0] idx,
                        input logic [31:0] dat, input logic [15:0] tid);
        int n;
        @(negedge clk);
        config_valid = 1'b1;
        config_addr  = {idx, blk, tid};
        config_data  = dat;
        #1;
        n = 0;
        while (!config_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL ready_timeout: config_ready stayed %b, expected 1", config_ready);
        end
        @(posedge clk); #1;
        config_valid = 1'b0;
        check("ready_after_accept", config_ready, (tid != TID));
    endtask

    task automatic cfg_write(input logic [7:0] blk, input logic [7:0] idx, input logic [31:0] dat,
                             input logic [15:0] tid, input logic exp_err);
        send(blk, idx, dat, tid);
        check("err_in_write", config_err, (tid == TID) && exp_err);
        @(posedge clk); #1;
        check("err_cleared", config_err, 0);
    endtask

    task automatic do_commit();
        int cnt;
        send(8'hFE, 8'h00, 32'h0, TID);
        cnt = 0;
        repeat (4) begin
            if (config_done) cnt++;
            @(posedge clk); #1;
        end
        check("done_pulse_width", cnt, 1);
    endtask

    // Power-on routing: side 0 mirrors side 1, every other side mirrors side 0
    task automatic check_default_routing();
        for (int i = 0; i < NL; i++) begin
            int s, t;
            s = i / NT; t = i % NT;
            exp_q.push_back(in_lane(((s == 0) ? 1 : 0) * NT + t));
        end
        for (int i = 0; i < NL; i++)
            check($sformatf("default_out_lane%0d", i), out_lane(i), exp_q.pop_front());
    endtask

    initial begin
        int cnt;
        vecs[0] = '{3'd0, 16'h1234, 16'h0001, 16'h1235};
        vecs[1] = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[2] = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000};
        vecs[3] = '{3'd3, 16'hF0F0, 16'h0F0F, 16'hFFFF};
        vecs[4] = '{3'd4, 16'hAAAA, 16'hFFFF, 16'h5555};
        vecs[5] = '{3'd5, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[6] = '{3'd6, 16'hBEEF, 16'h1234, 16'h1234};
        vecs[7] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[8] = '{3'd0, 16'hFFFF, 16'h0002, 16'h0001};

        reset        = 1'b0;
        tile_id      = TID;
        config_valid = 1'b0;
        config_addr  = '0;
        config_data  = '0;
        for (int i = 0; i < NL; i++) set_lane(i, 16'(16'h1111 * i));

        // Reset state
        #12;
        check("rst_done", config_done, 0);
        check("rst_err", config_err, 0);
        check("rst_ready", config_ready, 1);
        @(negedge clk); reset = 1'b1; #1;
        check("ready_after_release", config_ready, 1);
        @(posedge clk); #1;
        check("ready_first_edge", config_ready, 1);
        check_default_routing();
        check("default_pe_out", pe_out, 16'h0000);

        // cb0 -> s0t1, cb1 -> s0t2, upper payload bits set to prove they are ignored
        cfg_write(8'd0, 8'd0, 32'h0000_0009, TID, 1'b0);
        cfg_write(8'd1, 8'd0, 32'hFFFF_FFFA, TID, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cfg_write(8'd2, 8'd0, {29'h1FFF_FFFF, vecs[i].op}, TID, 1'b0);
            do_commit();
            @(negedge clk);
            set_lane(1, vecs[i].a);
            set_lane(2, vecs[i].b);
            exp_q.push_back(vecs[i].exp_pe);
            @(posedge clk); #1;
            check($sformatf("pe_vec%0d", i), pe_out, exp_q.pop_front());
        end

        // Request for another tile is consumed with no effect
        cfg_write(8'd2, 8'd0, 32'h7, 16'h0043, 1'b0);
        do_commit();
        check("foreign_tile_ignored", pe_out, 16'h0001);

        // Switch box: shadow write invisible until commit
        @(negedge clk);
        set_lane(1, 16'h1234);
        set_lane(2, 16'h0001);
        cfg_write(8'd3, 8'd5, 32'hFFFF_FFF3, TID, 1'b0);
        check("sb_shadow_no_effect", out_lane(5), 16'h1234);
        do_commit();
        check("pe_after_sb", pe_out, 16'h1235);
        check("sb_s1t1_pe", out_lane(5), 16'h1235);
        check("sb_s1t2_untouched", out_lane(6), 16'h0001);

        // Bad block and out-of-range sb index: error pulse, nothing written
        cfg_write(8'h07, 8'd0, 32'h0, TID, 1'b1);
        cfg_write(8'd3, 8'd16, 32'h3, TID, 1'b1);
        do_commit();
        check("err_no_pe_change", pe_out, 16'h1235);
        check("err_no_sb0_change", out_lane(0), 16'h4444);
        check("err_no_sb5_change", out_lane(5), 16'h1235);

        // Back-to-back valid: ready alternates high/low across accepts
        @(negedge clk);
        config_valid = 1'b1;
        config_addr  = {8'd0, 8'd0, TID};
        config_data  = 32'h1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("b2b_ready%0d", i), config_ready, (i % 2 == 0));
            @(negedge clk);
        end
        config_valid = 1'b0;

        // Reset during COMMIT discards it and clears everything
        cfg_write(8'd2, 8'd0, 32'h1, TID, 1'b0);
        send(8'hFE, 8'h00, 32'h0, TID);
        reset = 1'b0;
        #1;
        cnt = 0;
        repeat (3) begin
            if (config_done) cnt++;
            @(posedge clk); #1;
        end
        check("rst_commit_no_done", cnt, 0);
        check("rst_commit_err", config_err, 0);
        @(negedge clk); reset = 1'b1; #1;
        check("rst_commit_ready", config_ready, 1);
        check_default_routing();
        check("rst_commit_pe", pe_out, 16'h0000);
        do_commit();
        check("rst_shadow_zero_sb", out_lane(5), 16'h1234);
        check("rst_shadow_zero_pe", pe_out, 16'h0000);

        // PE output timing relative to an operand change (cb0=cb1=s0t0, op add)
        @(negedge clk); set_lane(0, 16'h0001);
        @(posedge clk); #1;
        check("lat_settle", pe_out, 16'h0002);
        @(negedge clk); set_lane(0, 16'h0005); #1;
`ifdef PE_OUTPUT_REG_EN
        check("lat_before_edge", pe_out, 16'h0002);
        @(posedge clk); #1;
        check("lat_after_edge", pe_out, 16'h000A);
`else
        check("lat_comb", pe_out, 16'h000A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
